// File: rtl/rs_decode_syndrome_if.sv
// Symbol-stream input and parallel-syndrome output bundle for rs_decode_syndrome.
// master = symbol source / syndrome sink, slave = the syndrome calculator.
interface rs_decode_syndrome_if #(
    parameter int NSYN = 16
);
    logic                enable;
    logic                in_valid;
    logic                in_sop;
    logic [7:0]          in_data;
    logic [8*NSYN-1:0]   syn;
    logic                syn_valid;
    logic                syn_ready;
    logic                syn_zero;
    logic                seq_err;
    logic                ovf;

    modport master (
        output enable, in_valid, in_sop, in_data, syn_ready,
        input  syn, syn_valid, syn_zero, seq_err, ovf
    );

    modport slave (
        input  enable, in_valid, in_sop, in_data, syn_ready,
        output syn, syn_valid, syn_zero, seq_err, ovf
    );
endinterface

// File: rtl/rs_decode_syndrome.sv
// RS(N,K) syndrome calculator over GF(2^8)/0x187: Horner accumulation, one symbol per enabled cycle,
// syndromes registered on the last symbol (visible next cycle). Macro RS_SYN_ZERO_DET_EN builds syn_zero.
module rs_decode_syndrome #(
    parameter int N   = 255,
    parameter int K   = 239,
    parameter int FCR = 0
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    rs_decode_syndrome_if.slave  io_bus
);
    localparam int         NSYN     = N - K;
    localparam logic [7:0] LAST_CNT = 8'(N - 1);

    typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;

    function automatic logic [7:0] gf_xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h87 : 8'h00);
    endfunction

    function automatic logic [7:0] gf_alpha_pow(input int e);
        logic [7:0] p;
        p = 8'h01;
        for (int k = 0; k < (e % 255); k++) p = gf_xtime(p);
        return p;
    endfunction

    // With a constant b this collapses to a fixed XOR network.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) acc = acc ^ sh;
            sh = gf_xtime(sh);
        end
        return acc;
    endfunction

    state_t             r_state;
    state_t             w_state_nxt;
    logic [7:0]         r_cnt;
    logic [8*NSYN-1:0]  r_acc;
    logic [8*NSYN-1:0]  r_syn;
    logic               r_syn_valid;
    logic               r_seq_err;
    logic               r_ovf;

    logic               w_sym;
    logic               w_xfer;
    logic               w_load;
    logic               w_step;
    logic               w_last;
    logic               w_seq_err;
    logic [8*NSYN-1:0]  w_horner;

    assign w_sym  = io_bus.enable & io_bus.in_valid;
    assign w_xfer = io_bus.enable & r_syn_valid & io_bus.syn_ready;

    for (genvar gi = 0; gi < NSYN; gi++) begin : g_horner
        localparam logic [7:0] ROOT = gf_alpha_pow(FCR + gi);
        assign w_horner[8*gi +: 8] = gf_mul(r_acc[8*gi +: 8], ROOT) ^ io_bus.in_data;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_sym) begin
            case (r_state)
                IDLE:    if (io_bus.in_sop) w_state_nxt = ACCUM;
                ACCUM:   if (!io_bus.in_sop && (r_cnt == LAST_CNT)) w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // A sop always restarts the word; in ACCUM that also flags the truncated word.
    always_comb begin
        w_load    = 1'b0;
        w_step    = 1'b0;
        w_last    = 1'b0;
        w_seq_err = 1'b0;
        if (w_sym) begin
            case (r_state)
                IDLE: begin
                    w_load    = io_bus.in_sop;
                    w_seq_err = !io_bus.in_sop;
                end
                ACCUM: begin
                    w_load    = io_bus.in_sop;
                    w_seq_err = io_bus.in_sop;
                    w_step    = !io_bus.in_sop && (r_cnt != LAST_CNT);
                    w_last    = !io_bus.in_sop && (r_cnt == LAST_CNT);
                end
                default: begin
                    w_load    = 1'b0;
                end
            endcase
        end
    end

    // The last symbol's Horner result goes straight to syn; the accumulator is left stale.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= 8'd0;
            r_acc <= '0;
        end else if (w_load) begin
            r_cnt <= 8'd1;
            r_acc <= {NSYN{io_bus.in_data}};
        end else if (w_step) begin
            r_cnt <= r_cnt + 8'd1;
            r_acc <= w_horner;
        end else if (w_last) begin
            r_cnt <= 8'd0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_syn       <= '0;
            r_syn_valid <= 1'b0;
            r_seq_err   <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_seq_err <= w_seq_err;
            r_ovf     <= w_last & r_syn_valid & ~w_xfer;
            if (w_last) begin
                r_syn       <= w_horner;
                r_syn_valid <= 1'b1;
            end else if (w_xfer) begin
                r_syn_valid <= 1'b0;
            end
        end
    end

`ifdef RS_SYN_ZERO_DET_EN
    logic r_syn_zero;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)       r_syn_zero <= 1'b0;
        else if (w_last) r_syn_zero <= ~|w_horner;
    end

    assign io_bus.syn_zero = r_syn_zero;
`else
    assign io_bus.syn_zero = 1'b0;
`endif

    assign io_bus.syn       = r_syn;
    assign io_bus.syn_valid = r_syn_valid;
    assign io_bus.seq_err   = r_seq_err;
    assign io_bus.ovf       = r_ovf;
endmodule
